lfrag_cfg_loader: RTL and testbench

Configuration-side writer for the logic-cell fabric: deserializes a serial config bitstream into the FRAME_BITS-wide lFragBitInfo vector consumed by a LOGIC block (16 bits per cell, 8 cells).
- Frames are staged in a shadow register and committed atomically, so the cells never see a partial frame.
- Also serially reads back the committed frame for verification.

---
 rtl/lfrag_cfg_loader_if.sv | 30 +++
 rtl/lfrag_cfg_loader.sv | 197 +++++++++++++++++++
 tb/tb_lfrag_cfg_loader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfrag_cfg_loader_if.sv
// Loader bus: serial config load handshake, serial readback stream, committed frame and status.
// Latency: none (signal bundle only).
// Backpressure: CFG_READY qualifies CFG_VALID on the load side; the readback stream has none.
interface lfrag_cfg_loader_if #(
    parameter int FRAME_BITS = 128
);
    logic                  CFG_START;
    logic                  CFG_DI;
    logic                  CFG_VALID;
    logic                  CFG_READY;
    logic                  RB_START;
    logic                  CFG_DO;
    logic                  CFG_DO_VALID;
    logic [FRAME_BITS-1:0] lFragBitInfo;
    logic                  LOAD_DONE;
    logic                  CFG_ERR;
    logic                  BUSY;

    // Configuration controller side
    modport master (
        output CFG_START, CFG_DI, CFG_VALID, RB_START,
        input  CFG_READY, CFG_DO, CFG_DO_VALID, lFragBitInfo, LOAD_DONE, CFG_ERR, BUSY
    );

    // Loader side
    modport slave (
        input  CFG_START, CFG_DI, CFG_VALID, RB_START,
        output CFG_READY, CFG_DO, CFG_DO_VALID, lFragBitInfo, LOAD_DONE, CFG_ERR, BUSY
    );
endinterface

// File: rtl/lfrag_cfg_loader.sv
// Deserializes a config bitstream into a shadow frame, commits it atomically to lFragBitInfo, serial readback.
// Latency: frame visible with LOAD_DONE one cycle after the last accepted bit; readback beat 0 one cycle after RB_START.
// Backpressure: CFG_READY low outside SHIFT/CRC; readback has none. Optional CRC-8 check: define CFG_CRC_EN.
module lfrag_cfg_loader #(
    parameter int FRAME_BITS = 128,
    parameter int CNT_W      = 8
) (
    input  logic               QCK,
    input  logic               QRTN,
    lfrag_cfg_loader_if.slave  bus
);

    localparam int               IDX_W     = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_BITS - 1);

`ifdef CFG_CRC_EN
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(7);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT    = 3'd1,
        S_CRC      = 3'd2,
        S_COMMIT   = 3'd3,
        S_READBACK = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT    = 3'd1,
        S_COMMIT   = 3'd3,
        S_READBACK = 3'd4
    } state_t;
`endif

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [FRAME_BITS-1:0] r_shadow;
    logic [FRAME_BITS-1:0] r_lfrag;
    logic                  r_ready;
    logic                  r_do;
    logic                  r_do_vld;
    logic                  r_done;
    logic                  r_err;
    logic                  r_busy;

    logic [CNT_W-1:0]      w_cnt_inc;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_rb_idx;
    logic                  w_accept;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_idx     = r_cnt[IDX_W-1:0];
    assign w_rb_idx  = w_cnt_inc[IDX_W-1:0];
    assign w_accept  = bus.CFG_VALID & r_ready;

`ifdef CFG_CRC_EN
    logic [7:0] r_crc;
    logic [7:0] r_rx;
    logic       w_crc_fb;
    logic [7:0] w_crc_nxt;
    logic [7:0] w_rx_full;

    // Serial CRC-8 (poly 0x07) step over the incoming data bit; received CRC shifts in MSB first
    assign w_crc_fb  = r_crc[7] ^ bus.CFG_DI;
    assign w_crc_nxt = {r_crc[6:0], 1'b0} ^ (w_crc_fb ? 8'h07 : 8'h00);
    assign w_rx_full = {r_rx[6:0], bus.CFG_DI};
`endif

    // Load / commit / readback sequencer; every output is a register updated here
    always_ff @(posedge QCK or negedge QRTN) begin
        if (!QRTN) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_lfrag  <= '0;
            r_ready  <= 1'b0;
            r_do     <= 1'b0;
            r_do_vld <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
`ifdef CFG_CRC_EN
            r_crc    <= '0;
            r_rx     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A load request always beats a simultaneous readback request
                    if (bus.CFG_START) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef CFG_CRC_EN
                        r_crc   <= '0;
`endif
                    end else if (bus.RB_START) begin
                        r_state  <= S_READBACK;
                        r_cnt    <= '0;
                        r_do     <= r_lfrag[0];
                        r_do_vld <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Restart discards the partial frame and the bit offered this cycle
                    if (bus.CFG_START) begin
                        r_cnt <= '0;
                        r_err <= 1'b1;
`ifdef CFG_CRC_EN
                        r_crc <= '0;
`endif
                    end else if (w_accept) begin
                        r_shadow[w_idx] <= bus.CFG_DI;
`ifdef CFG_CRC_EN
                        r_crc <= w_crc_nxt;
`endif
                        if (r_cnt == LAST_DATA) begin
                            r_cnt <= '0;
`ifdef CFG_CRC_EN
                            r_state <= S_CRC;
`else
                            r_state <= S_COMMIT;
                            r_ready <= 1'b0;
`endif
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
`ifdef CFG_CRC_EN
                S_CRC: begin
                    if (bus.CFG_START) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_err   <= 1'b1;
                        r_crc   <= '0;
                    end else if (w_accept) begin
                        r_rx <= w_rx_full;
                        if (r_cnt == LAST_CRC) begin
                            r_cnt   <= '0;
                            r_ready <= 1'b0;
                            if (w_rx_full == r_crc) begin
                                r_state <= S_COMMIT;
                            end else begin
                                r_state <= S_IDLE;
                                r_err   <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
`endif
                S_COMMIT: begin
                    r_lfrag <= r_shadow;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_READBACK: begin
                    // r_cnt indexes the beat currently on CFG_DO
                    if (r_cnt == LAST_DATA) begin
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        r_do     <= 1'b0;
                        r_do_vld <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        r_do  <= r_lfrag[w_rb_idx];
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    r_ready  <= 1'b0;
                    r_do     <= 1'b0;
                    r_do_vld <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CFG_READY    = r_ready;
    assign bus.CFG_DO       = r_do;
    assign bus.CFG_DO_VALID = r_do_vld;
    assign bus.lFragBitInfo = r_lfrag;
    assign bus.LOAD_DONE    = r_done;
    assign bus.CFG_ERR      = r_err;
    assign bus.BUSY         = r_busy;

endmodule

// File: tb/tb_lfrag_cfg_loader.sv
// Directed bench for lfrag_cfg_loader: reset, back-to-back and gapped loads, abort, readback, CRC.
// Latency: checks LOAD_DONE one cycle after the last accepted bit, readback beat 0 one cycle after RB_START.
// Backpressure: inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_lfrag_cfg_loader;

    localparam int FB = 128;
`ifdef CFG_CRC_EN
    localparam int TAIL = 8;
`else
    localparam int TAIL = 0;
`endif

    logic QCK  = 1'b0;
    logic QRTN = 1'b0;

    lfrag_cfg_loader_if #(.FRAME_BITS(FB)) bus ();

    lfrag_cfg_loader #(.FRAME_BITS(FB), .CNT_W(8)) dut (
        .QCK  (QCK),
        .QRTN (QRTN),
        .bus  (bus)
    );

    always #5 QCK = ~QCK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [FB-1:0] PAT;
    logic [FB-1:0] ONES;
    logic [FB-1:0] RBV;

    task automatic step();
        @(posedge QCK);
        #1;
    endtask

    function automatic logic [7:0] crc8(input logic [FB-1:0] v);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < FB; i++) begin
            fb = c[7] ^ v[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Appends the CRC byte (MSB first) when the checked build is in use; optionally corrupts bit 0
    task automatic send_tail(input logic [FB-1:0] v, input logic flip0);
`ifdef CFG_CRC_EN
        logic [7:0] c;
        c = crc8(v) ^ {7'b0, flip0};
        for (int j = 7; j >= 0; j--) begin
            bus.CFG_DI    = c[j];
            bus.CFG_VALID = 1'b1;
            step();
        end
        bus.CFG_VALID = 1'b0;
`else
        if (flip0 && v[0]) bus.CFG_VALID = 1'b0;
`endif
    endtask

    // Start pulse plus a full back-to-back frame; returns just after the last accept edge
    task automatic load_frame(input logic [FB-1:0] v, input logic flip0);
        bus.CFG_START = 1'b1;
        step();
        bus.CFG_START = 1'b0;
        for (int i = 0; i < FB; i++) begin
            bus.CFG_DI    = v[i];
            bus.CFG_VALID = 1'b1;
            step();
        end
        bus.CFG_VALID = 1'b0;
        send_tail(v, flip0);
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        QRTN = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.CFG_START = 1'($urandom);
            bus.CFG_DI    = 1'($urandom);
            bus.CFG_VALID = 1'($urandom);
            bus.RB_START  = 1'($urandom);
            step();
            ctl = {bus.CFG_READY, bus.CFG_DO, bus.CFG_DO_VALID, bus.LOAD_DONE, bus.CFG_ERR, bus.BUSY};
            n_checks++;
            if (ctl !== 6'b0) $display("FAIL reset_ctl cycle %0d: got %b want 000000", c, ctl);
            else n_pass++;
            n_checks++;
            if (bus.lFragBitInfo !== '0) $display("FAIL reset_frame cycle %0d: got %h want 0", c, bus.lFragBitInfo);
            else n_pass++;
        end
        bus.CFG_START = 1'b0;
        bus.CFG_DI    = 1'b0;
        bus.CFG_VALID = 1'b0;
        bus.RB_START  = 1'b0;
        QRTN = 1'b1;
        step();
        n_checks++;
        if ({bus.BUSY, bus.CFG_READY} !== 2'b00) $display("FAIL reset_release_idle: got %b want 00", {bus.BUSY, bus.CFG_READY});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad;
        bus.CFG_START = 1'b1;
        step();
        bus.CFG_START = 1'b0;
        n_checks++;
        if ({bus.CFG_READY, bus.BUSY} !== 2'b11) $display("FAIL b2b_start: got ready/busy %b want 11", {bus.CFG_READY, bus.BUSY});
        else n_pass++;
        bad = 0;
        for (int i = 0; i < FB; i++) begin
            bus.CFG_DI    = PAT[i];
            bus.CFG_VALID = 1'b1;
            if (bus.CFG_READY !== 1'b1) bad++;
            step();
        end
        bus.CFG_VALID = 1'b0;
        send_tail(PAT, 1'b0);
        n_checks++;
        if (bad != 0) $display("FAIL b2b_ready_during_load: got %0d not-ready cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if ({bus.CFG_READY, bus.LOAD_DONE} !== 2'b00) $display("FAIL b2b_after_last: got ready/done %b want 00", {bus.CFG_READY, bus.LOAD_DONE});
        else n_pass++;
        n_checks++;
        if (bus.lFragBitInfo !== '0) $display("FAIL b2b_precommit_frame: got %h want 0", bus.lFragBitInfo);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.LOAD_DONE, bus.BUSY} !== 2'b10) $display("FAIL b2b_done: got done/busy %b want 10", {bus.LOAD_DONE, bus.BUSY});
        else n_pass++;
        n_checks++;
        if (bus.lFragBitInfo !== PAT) $display("FAIL b2b_frame: got %h want %h", bus.lFragBitInfo, PAT);
        else n_pass++;
        step();
        n_checks++;
        if (bus.LOAD_DONE !== 1'b0) $display("FAIL b2b_done_pulse: got %b want 0", bus.LOAD_DONE);
        else n_pass++;
    endtask

    task automatic test_abort();
        int bad;
        load_frame(ONES, 1'b0);
        step();
        n_checks++;
        if ({bus.LOAD_DONE, (bus.lFragBitInfo === ONES)} !== 2'b11) $display("FAIL abort_ones_commit: got %h want %h", bus.lFragBitInfo, ONES);
        else n_pass++;
        bus.CFG_START = 1'b1;
        step();
        bus.CFG_START = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.CFG_DI    = 1'b1;
            bus.CFG_VALID = 1'b1;
            step();
        end
        bus.CFG_START = 1'b1;
        bus.CFG_DI    = 1'b1;
        bus.CFG_VALID = 1'b1;
        step();
        bus.CFG_START = 1'b0;
        bus.CFG_VALID = 1'b0;
        n_checks++;
        if ({bus.CFG_ERR, bus.CFG_READY, bus.BUSY} !== 3'b111) $display("FAIL abort_flags: got err/ready/busy %b want 111", {bus.CFG_ERR, bus.CFG_READY, bus.BUSY});
        else n_pass++;
        bad = 0;
        for (int i = 0; i < FB; i++) begin
            bus.CFG_DI    = 1'b0;
            bus.CFG_VALID = 1'b1;
            if (bus.lFragBitInfo !== ONES) bad++;
            step();
        end
        bus.CFG_VALID = 1'b0;
        send_tail('0, 1'b0);
        n_checks++;
        if (bad != 0) $display("FAIL abort_frame_held: got %0d cycles with changed frame want 0", bad);
        else n_pass++;
        n_checks++;
        if ({bus.CFG_READY, bus.LOAD_DONE} !== 2'b00) $display("FAIL abort_reload_count: got ready/done %b want 00", {bus.CFG_READY, bus.LOAD_DONE});
        else n_pass++;
        step();
        n_checks++;
        if ({bus.LOAD_DONE, bus.CFG_ERR} !== 2'b11) $display("FAIL abort_commit_err: got done/err %b want 11", {bus.LOAD_DONE, bus.CFG_ERR});
        else n_pass++;
        n_checks++;
        if (bus.lFragBitInfo !== '0) $display("FAIL abort_commit_frame: got %h want 0", bus.lFragBitInfo);
        else n_pass++;
        bus.CFG_START = 1'b1;
        step();
        bus.CFG_START = 1'b0;
        n_checks++;
        if ({bus.CFG_ERR, bus.BUSY} !== 2'b01) $display("FAIL abort_err_clear: got err/busy %b want 01", {bus.CFG_ERR, bus.BUSY});
        else n_pass++;
        for (int i = 0; i < FB; i++) begin
            bus.CFG_DI    = 1'b0;
            bus.CFG_VALID = 1'b1;
            step();
        end
        bus.CFG_VALID = 1'b0;
        send_tail('0, 1'b0);
        step();
        step();
    endtask

    task automatic test_gapped();
        int bad;
        int n;
        bad = 0;
        n   = 0;
        bus.CFG_START = 1'b1;
        step();
        bus.CFG_START = 1'b0;
        for (int i = 0; i < FB; i++) begin
            bus.CFG_DI    = ~PAT[i];
            bus.CFG_VALID = 1'b0;
            if (bus.lFragBitInfo !== '0) bad++;
            step();
            n++;
            bus.CFG_DI    = PAT[i];
            bus.CFG_VALID = 1'b1;
            if (bus.lFragBitInfo !== '0) bad++;
            step();
            n++;
        end
        bus.CFG_VALID = 1'b0;
        send_tail(PAT, 1'b0);
        n = n + TAIL;
        while (bus.LOAD_DONE !== 1'b1 && n < 400) begin
            if (bus.lFragBitInfo !== '0) bad++;
            step();
            n++;
        end
        n_checks++;
        if (n != 257 + TAIL) $display("FAIL gap_done_cycle: got %0d want %0d", n, 257 + TAIL);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL gap_frame_held: got %0d early changes want 0", bad);
        else n_pass++;
        n_checks++;
        if (bus.lFragBitInfo !== PAT) $display("FAIL gap_frame: got %h want %h", bus.lFragBitInfo, PAT);
        else n_pass++;
        step();
    endtask

    task automatic test_readback();
        int bad;
        int bad_v;
        int bad_d;
        bus.CFG_START = 1'b1;
        bus.RB_START  = 1'b1;
        step();
        bus.CFG_START = 1'b0;
        bus.RB_START  = 1'b0;
        n_checks++;
        if ({bus.CFG_READY, bus.CFG_DO_VALID} !== 2'b10) $display("FAIL rb_start_priority: got ready/do_valid %b want 10", {bus.CFG_READY, bus.CFG_DO_VALID});
        else n_pass++;
        bad = 0;
        for (int i = 0; i < FB; i++) begin
            bus.CFG_DI    = RBV[i];
            bus.CFG_VALID = 1'b1;
            if (bus.CFG_DO_VALID !== 1'b0) bad++;
            step();
        end
        bus.CFG_VALID = 1'b0;
        send_tail(RBV, 1'b0);
        step();
        n_checks++;
        if (bus.lFragBitInfo !== RBV) $display("FAIL rb_frame: got %h want %h", bus.lFragBitInfo, RBV);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL rb_no_stream_during_load: got %0d valid beats want 0", bad);
        else n_pass++;
        step();
        bus.RB_START = 1'b1;
        step();
        bus.RB_START = 1'b0;
        bad_v = 0;
        bad_d = 0;
        for (int k = 0; k < FB; k++) begin
            if ({bus.CFG_DO_VALID, bus.BUSY, bus.CFG_READY} !== 3'b110) bad_v++;
            if (bus.CFG_DO !== RBV[k]) bad_d++;
            bus.CFG_START = (k == 5);
            bus.RB_START  = (k == 10);
            step();
        end
        bus.CFG_START = 1'b0;
        bus.RB_START  = 1'b0;
        n_checks++;
        if (bad_v != 0) $display("FAIL rb_valid_beats: got %0d bad beats want 0", bad_v);
        else n_pass++;
        n_checks++;
        if (bad_d != 0) $display("FAIL rb_data_beats: got %0d wrong bits want 0", bad_d);
        else n_pass++;
        n_checks++;
        if ({bus.CFG_DO_VALID, bus.BUSY, bus.CFG_DO} !== 3'b000) $display("FAIL rb_end: got do_valid/busy/do %b want 000", {bus.CFG_DO_VALID, bus.BUSY, bus.CFG_DO});
        else n_pass++;
    endtask

    task automatic test_reset_mid_shift();
        bus.CFG_START = 1'b1;
        step();
        bus.CFG_START = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus.CFG_DI    = PAT[i];
            bus.CFG_VALID = 1'b1;
            step();
        end
        bus.CFG_VALID = 1'b0;
        #2;
        QRTN = 1'b0;
        #1;
        n_checks++;
        if ({bus.BUSY, bus.CFG_READY} !== 2'b00) $display("FAIL midreset_ctl: got busy/ready %b want 00", {bus.BUSY, bus.CFG_READY});
        else n_pass++;
        n_checks++;
        if (bus.lFragBitInfo !== '0) $display("FAIL midreset_frame: got %h want 0", bus.lFragBitInfo);
        else n_pass++;
        step();
        QRTN = 1'b1;
        step();
        load_frame(PAT, 1'b0);
        step();
        n_checks++;
        if ({bus.LOAD_DONE, (bus.lFragBitInfo === PAT)} !== 2'b11) $display("FAIL midreset_reload: got %h want %h", bus.lFragBitInfo, PAT);
        else n_pass++;
        step();
    endtask

`ifdef CFG_CRC_EN
    task automatic test_crc();
        int seen;
        load_frame(~PAT, 1'b1);
        n_checks++;
        if ({bus.CFG_ERR, bus.BUSY, bus.CFG_READY} !== 3'b100) $display("FAIL crc_bad_flags: got err/busy/ready %b want 100", {bus.CFG_ERR, bus.BUSY, bus.CFG_READY});
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.LOAD_DONE !== 1'b0) seen++;
            step();
        end
        n_checks++;
        if (seen != 0) $display("FAIL crc_bad_no_done: got %0d done cycles want 0", seen);
        else n_pass++;
        n_checks++;
        if (bus.lFragBitInfo !== PAT) $display("FAIL crc_bad_frame: got %h want %h", bus.lFragBitInfo, PAT);
        else n_pass++;
        load_frame(~PAT, 1'b0);
        step();
        n_checks++;
        if ({bus.LOAD_DONE, bus.CFG_ERR, (bus.lFragBitInfo === ~PAT)} !== 3'b101) $display("FAIL crc_good_commit: got %h want %h", bus.lFragBitInfo, ~PAT);
        else n_pass++;
        step();
    endtask
`endif

    initial begin
        bus.CFG_START = 1'b0;
        bus.CFG_DI    = 1'b0;
        bus.CFG_VALID = 1'b0;
        bus.RB_START  = 1'b0;
        PAT  = 128'h0123456789ABCDEF_FEDCBA9876543210;
        ONES = '1;
        RBV  = '0;
        RBV[0]      = 1'b1;
        RBV[FB - 1] = 1'b1;
        test_reset();
        test_back_to_back();
        test_abort();
        test_gapped();
        test_readback();
        test_reset_mid_shift();
`ifdef CFG_CRC_EN
        test_crc();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
